// File: rtl/mem_flash_loader_if.sv
// Byte-stream input and flash write port of the boot loader.
// The loader connects through master; the byte source and memory through slave.
interface mem_flash_loader_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 11
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  flash_en;
  logic [ADDR_WIDTH-1:0] flash_addr;
  logic [WIDTH-1:0]      flash_data;

  modport master (
    input  in_valid, in_data,
    output in_ready, flash_en, flash_addr, flash_data
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, flash_en, flash_addr, flash_data
  );
endinterface

// File: rtl/mem_flash_loader.sv
// Boot loader: receives a length-prefixed little-endian byte image, writes it
// word by word to the flash port, verifies a trailing checksum, holds busy until done.
module mem_flash_loader #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_WORDS  = (2 ** ADDR_WIDTH) / (WIDTH / 8)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  mem_flash_loader_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               error
);
  localparam int BPW  = WIDTH / 8;
  localparam int LG   = $clog2(BPW);
  localparam int IDXW = 10;

  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t state, state_next;

  logic [7:0]       len_lo;
  logic [15:0]      len;
  logic [LG-1:0]    byte_cnt;
  logic [IDXW-1:0]  word_idx;
  logic [7:0]       csum;
  logic [WIDTH-9:0] word_buf;

  logic             xfer;
  logic             last_byte;
  logic [15:0]      len_rx;
  logic [15:0]      idx_inc;
  logic [WIDTH-1:0] word_shift;

  assign bus.in_ready = rst && (state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK});
  assign xfer         = bus.in_valid && bus.in_ready;
  assign last_byte    = (byte_cnt == LG'(BPW - 1));
  assign len_rx       = {bus.in_data, len_lo};
  assign idx_inc      = 16'(word_idx) + 16'd1;
  // Newest byte enters at the top, so the first byte of a word ends up in [7:0].
  assign word_shift   = {bus.in_data, word_buf};

  always_ff @(posedge clk) begin
    if (!rst) state <= S_LEN_LO;
    else      state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      S_LEN_LO: if (xfer) state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (xfer) begin
          if (len_rx > 16'(MAX_WORDS)) state_next = S_ERROR;
          else if (len_rx == 16'd0)    state_next = S_CHECK;
          else                         state_next = S_DATA;
        end
      end
      S_DATA:   if (xfer && last_byte) state_next = S_WRITE;
      S_WRITE:  state_next = (idx_inc < len) ? S_DATA : S_CHECK;
      S_CHECK:  if (xfer) state_next = (bus.in_data == csum) ? S_DONE : S_ERROR;
      S_DONE, S_ERROR: if (restart) state_next = S_LEN_LO;
      default:  state_next = S_LEN_LO;
    endcase
  end

  // Status and strobe are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      bus.flash_en   <= 1'b0;
      bus.flash_addr <= '0;
      bus.flash_data <= '0;
      busy           <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
      len_lo         <= '0;
      len            <= '0;
      byte_cnt       <= '0;
      word_idx       <= '0;
      csum           <= '0;
      word_buf       <= '0;
    end else begin
      bus.flash_en <= (state_next == S_WRITE);
      done         <= (state_next == S_DONE);
      error        <= (state_next == S_ERROR);
      busy         <= !(state_next inside {S_DONE, S_ERROR});
      unique case (state)
        S_LEN_LO: if (xfer) len_lo <= bus.in_data;
        S_LEN_HI: if (xfer) len <= len_rx;
        S_DATA: begin
          if (xfer) begin
            word_buf <= word_shift[WIDTH-1:8];
            csum     <= csum + bus.in_data;
            byte_cnt <= byte_cnt + 1'b1;
            if (last_byte) begin
              bus.flash_addr <= ADDR_WIDTH'({word_idx, {LG{1'b0}}});
              bus.flash_data <= word_shift;
            end
          end
        end
        S_WRITE: word_idx <= word_idx + 1'b1;
        S_DONE, S_ERROR: begin
          if (restart) begin
            len_lo   <= '0;
            len      <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
            csum     <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_flash_loader.sv
// Directed bench for mem_flash_loader: expected flash writes are queued as each
// image is sent and matched against the strobes the loader produces.
module tb_mem_flash_loader;
  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 11;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic restart = 1'b0;
  logic busy, done, error;

  mem_flash_loader_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  mem_flash_loader #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  failures = 0;
  int  n_writes = 0;
  bit  mon_en = 1'b0;
  wr_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready_decode", 32'(bus.in_ready), 32'(rst && busy && !bus.flash_en));
      if (bus.flash_en === 1'b1) begin
        wr_t e;
        n_writes++;
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("flash_addr", 32'(bus.flash_addr), 32'(e.addr));
          check("flash_data", bus.flash_data, e.data);
        end
      end
    end
  end

  task automatic push_exp(input logic [ADDR_WIDTH-1:0] a, input logic [WIDTH-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_s1();
    push_exp(11'd0, 32'h0000_3039);
    push_exp(11'd4, 32'h000A_5BFE);
    push_exp(11'd8, 32'hDEAD_BEEF);
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit gap);
    foreach (s[i]) send_byte(s[i], gap);
  endtask

  task automatic end_checks(input string tag, input bit exp_done, input bit exp_err,
                            input int exp_writes);
    int t;
    t = 0;
    while (!(done === 1'b1 || error === 1'b1) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check({tag, "_end_timeout"}, 32'(done | error), 32'd1);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_writes"}, 32'(n_writes), 32'(exp_writes));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_done", 32'(done), 32'd0);
    check("restart_error", 32'(error), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    n_writes = 0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_flash_en"}, 32'(bus.flash_en), 32'd0);
    check({tag, "_flash_addr"}, 32'(bus.flash_addr), 32'd0);
    check({tag, "_flash_data"}, bus.flash_data, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s1[$];
    logic [7:0] s2[$];
    logic [7:0] s3[$];
    s1 = '{8'h03, 8'h00, 8'h39, 8'h30, 8'h00, 8'h00, 8'hFE, 8'h5B,
           8'h0A, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04};
    s3 = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    reset_checks("reset");
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    // Normal load, back to back.
    push_s1();
    send_stream(s1, 1'b0);
    end_checks("normal", 1'b1, 1'b0, 3);
    do_restart();

    // Bad checksum; a restart pulse mid-data must be ignored.
    s2 = s1;
    s2[s2.size() - 1] = 8'h05;
    push_s1();
    foreach (s2[i]) begin
      if (i == 4) begin
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_ignored_busy", 32'(busy), 32'd1);
      end
      send_byte(s2[i], 1'b0);
    end
    end_checks("bad_csum", 1'b0, 1'b1, 3);
    do_restart();

    // Length overflow: N = 513.
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    check("overflow_error_next_cycle", 32'(error), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      check("overflow_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    end_checks("overflow", 1'b0, 1'b1, 0);
    do_restart();

    // Zero length, good and bad checksum.
    send_stream('{8'h00, 8'h00, 8'h00}, 1'b0);
    end_checks("zero_ok", 1'b1, 1'b0, 0);
    do_restart();
    send_stream('{8'h00, 8'h00, 8'h7F}, 1'b0);
    end_checks("zero_bad", 1'b0, 1'b1, 0);
    do_restart();

    // Scenario 1 with an idle cycle after every byte.
    push_s1();
    send_stream(s1, 1'b1);
    end_checks("gaps", 1'b1, 1'b0, 3);
    do_restart();

    // Reset after the 6th byte: word 0 has already been written, nothing more.
    push_exp(11'd0, 32'h0000_3039);
    for (int i = 0; i < 6; i++) send_byte(s1[i], 1'b0);
    @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    reset_checks("midload_reset");
    rst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    check("midload_writes", 32'(n_writes), 32'd1);
    check("midload_queue_empty", 32'(exp_q.size()), 32'd0);
    n_writes = 0;

    push_s1();
    send_stream(s1, 1'b0);
    end_checks("replay", 1'b1, 1'b0, 3);
    do_restart();

    push_exp(11'd0, 32'h1234_5678);
    send_stream(s3, 1'b0);
    end_checks("after_restart", 1'b1, 1'b0, 1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_flash_loader.md
Name: mem_flash_loader

Overview:
- Boot-time loader sitting directly upstream of `memory`'s flash port (`flash_en`/`flash_addr`/`flash_data`).
- Accepts a byte stream over a valid/ready handshake (e.g. from a UART RX block).
- Assembles little-endian words and writes them to consecutive word addresses from 0.
- Verifies a trailing checksum; holds the core in reset via `busy` until the image is loaded.

Parameters:
- WIDTH, 32, data word width; must equal `memory` WIDTH; bytes per word BPW = WIDTH/8.
- ADDR_WIDTH, 11, byte-address width of the flash port.
- MAX_WORDS, 2**ADDR_WIDTH/BPW (512), largest accepted word count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- restart  in  1  single-cycle pulse; re-arms the loader from DONE or ERROR.
- in_valid  in  1  upstream byte valid.
- in_data  in  8  upstream byte.
- in_ready  out  1  loader can accept a byte; transfer occurs when in_valid && in_ready at clk edge.
- flash_en  out  1  one-cycle write strobe to memory.
- flash_addr  out  ADDR_WIDTH  byte address of write; always word-aligned.
- flash_data  out  WIDTH  assembled word.
- busy  out  1  1 while loading; drives core hold.
- done  out  1  image loaded and checksum matched.
- error  out  1  length overflow or checksum mismatch.

Behaviour:
- Stream format:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - N*BPW data bytes: each word little-endian, first byte → bits [7:0].
  - One checksum byte: sum of all data bytes mod 256; header bytes excluded.
- Reset (rst=0 at edge):
  - Outputs: in_ready=0, flash_en=0, flash_addr=0, flash_data=0, busy=1, done=0, error=0.
  - Internal: state←LEN_LO, byte/word counters←0, checksum accumulator←0.
  - Applies in any state, including mid-load; the partial image is abandoned and no further flash_en is issued.
- States:
  - LEN_LO: in_ready=1; on transfer latch the count low byte → LEN_HI.
  - LEN_HI: in_ready=1; on transfer latch the high byte, then:
    - N > MAX_WORDS → ERROR.
    - N = 0 → CHECK.
    - Otherwise → DATA.
  - DATA: in_ready=1; on transfer shift the byte into the word buffer and add it to the checksum.
    - After byte BPW-1 of a word → WRITE.
  - WRITE: lasts exactly one cycle, entered the cycle after the last byte of the word is accepted.
    - in_ready=0; flash_en=1; flash_addr=word_idx*BPW; flash_data=assembled word.
    - Next cycle: flash_en=0 and word_idx+1; then → DATA if word_idx+1 < N, else → CHECK.
  - CHECK: in_ready=1; on transfer compare the received byte with the accumulator.
    - Equal → DONE; unequal → ERROR.
  - DONE: busy=0, done=1, in_ready=0.
  - ERROR: busy=0, error=1, in_ready=0.
  - DONE and ERROR are held until restart=1 (→ LEN_LO, counters cleared, done/error cleared) or reset.
  - restart is ignored in all other states.
- Outputs from registers: flash_en, flash_addr, flash_data, busy, done, error. in_ready may be decoded from state.
- flash_addr/flash_data hold their last value when flash_en=0.
- in_valid gaps in any state simply stall; no timeout.
- Writes already issued before a checksum mismatch remain in memory; error only flags the failure.
- Maximum throughput: BPW bytes per BPW+1 cycles.
- Counters:
  - word_idx is 10 bits wide, enough to hold MAX_WORDS.
  - flash_addr = word_idx shifted left by log2(BPW), truncated to ADDR_WIDTH; no wrap is possible because N ≤ MAX_WORDS.
  - Checksum accumulator is 8-bit, wrapping.

Test Plan:
1. Normal load: stream 03 00 39 30 00 00 FE 5B 0A 00 EF BE AD DE 04.
   - Exactly three flash_en pulses: (0, 0x00003039), (4, 0x000A5BFE), (8, 0xDEADBEEF).
   - done=1, busy=0, error=0.
   - `memory` reads at addr 0/4/8 return those words.
2. Bad checksum: same stream with final byte 05.
   - Same three writes occur; error=1, done=0, busy=0.
3. Length overflow: stream 01 02 (N=513).
   - error=1 the cycle after LEN_HI is accepted; no flash_en; further bytes are not accepted (in_ready=0).
4. Zero length: stream 00 00 00 → done=1 with no flash_en. Zero length with checksum 7F → error=1.
5. Backpressure/gaps: scenario 1 with in_valid toggled 1/0 every cycle.
   - Identical writes and done.
   - in_ready=0 exactly during each WRITE cycle; a byte presented then is held and accepted on the next cycle.
6. Reset and restart:
   - Reset mid-load: drive rst=0 for one cycle after the 6th byte of scenario 1 → all outputs at reset values, no pulse for the partial word.
   - Replay the full scenario 1 → correct load.
   - Then pulse restart from DONE and load 01 00 78 56 34 12 14 → write (0, 0x12345678), done=1.
